// File: rtl/axi4_lite_reg_slave_if.sv
`default_nettype none
// ============================================================================
// axi4_if : AXI4-Lite channel bundle (AW, W, B, AR, R) with master/slave views.
// Revision: 1.0
// ============================================================================
interface axi4_if #(
  parameter int A = 8,
  parameter int N = 4,
  parameter int I = 1
);
  logic           awvalid;
  logic           awready;
  logic [A-1:0]   awaddr;
  logic [I-1:0]   awid;
  logic           wvalid;
  logic           wready;
  logic [N*8-1:0] wdata;
  logic [N-1:0]   wstrb;
  logic           bvalid;
  logic           bready;
  logic [1:0]     bresp;
  logic [I-1:0]   bid;
  logic           arvalid;
  logic           arready;
  logic [A-1:0]   araddr;
  logic [I-1:0]   arid;
  logic           rvalid;
  logic           rready;
  logic [N*8-1:0] rdata;
  logic [1:0]     rresp;
  logic [I-1:0]   rid;

  modport master (
    output awvalid, awaddr, awid, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arid, rready,
    input  awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rid
  );

  modport slave (
    input  awvalid, awaddr, awid, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arid, rready,
    output awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rid
  );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// axi4_lite_reg_slave : AXI4-Lite register file of R words x N bytes.
// Optional macro AXI4_LITE_REG_SLAVE_DECERR_EN: out-of-range accesses -> DECERR.
// Revision: 1.0
// ============================================================================
module axi4_lite_reg_slave #(
  parameter int A = 8,
  parameter int N = 4,
  parameter int I = 1,
  parameter int R = 8
) (
  input  wire              aclk,
  input  wire              aresetn,
  axi4_if.slave            axi4_s,
  output logic [R*N*8-1:0] reg_q,
  output logic [R-1:0]     wr_pulse
);

  localparam int c_DW    = N * 8;
  localparam int c_OFF_W = $clog2(N);
  localparam int c_IDX_W = $clog2(R);

`ifdef AXI4_LITE_REG_SLAVE_DECERR_EN
  localparam logic [1:0] c_OOR_RESP = 2'b11;
`else
  localparam logic [1:0] c_OOR_RESP = 2'b00;
`endif

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  function automatic logic addr_ok(input logic [A-1:0] addr);
    return {1'b0, addr} < (A+1)'(R * N);
  endfunction

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic               r_aw_held, r_w_held;
  logic [A-1:0]       r_awaddr;
  logic [I-1:0]       r_awid;
  logic [c_DW-1:0]    r_wdata;
  logic [N-1:0]       r_wstrb;
  logic [1:0]         r_bresp;
  logic [I-1:0]       r_bid;
  logic [c_DW-1:0]    r_rdata;
  logic [1:0]         r_rresp;
  logic [I-1:0]       r_rid;
  logic [c_DW-1:0]    r_regs [R];
  logic [R-1:0]       r_wr_pulse;

  logic               w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_ok;
  logic [A-1:0]       w_cur_awaddr;
  logic [I-1:0]       w_cur_awid;
  logic [c_DW-1:0]    w_cur_wdata;
  logic [N-1:0]       w_cur_wstrb;
  logic [c_IDX_W-1:0] w_widx, w_ridx;

  // Handshakes are derived from state directly so that the ready outputs of
  // the FSM process never feed back into its own next-state inputs.
  assign w_aw_hs  = (r_wstate == W_IDLE) & ~r_aw_held & axi4_s.awvalid;
  assign w_w_hs   = (r_wstate == W_IDLE) & ~r_w_held  & axi4_s.wvalid;
  assign w_ar_hs  = (r_rstate == R_IDLE) & axi4_s.arvalid;
  assign w_commit = (r_wstate == W_IDLE) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

  assign w_cur_awaddr = r_aw_held ? r_awaddr : axi4_s.awaddr;
  assign w_cur_awid   = r_aw_held ? r_awid   : axi4_s.awid;
  assign w_cur_wdata  = r_w_held  ? r_wdata  : axi4_s.wdata;
  assign w_cur_wstrb  = r_w_held  ? r_wstrb  : axi4_s.wstrb;
  assign w_wr_ok      = addr_ok(w_cur_awaddr);
  assign w_widx       = w_cur_awaddr[c_OFF_W +: c_IDX_W];
  assign w_ridx       = axi4_s.araddr[c_OFF_W +: c_IDX_W];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt   = r_wstate;
    axi4_s.awready = 1'b0;
    axi4_s.wready  = 1'b0;
    axi4_s.bvalid  = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        axi4_s.awready = ~r_aw_held;
        axi4_s.wready  = ~r_w_held;
        if (w_commit) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        axi4_s.bvalid = 1'b1;
        if (axi4_s.bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt   = r_rstate;
    axi4_s.arready = 1'b0;
    axi4_s.rvalid  = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        axi4_s.arready = 1'b1;
        if (axi4_s.arvalid) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        axi4_s.rvalid = 1'b1;
        if (axi4_s.rready) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_awid    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= 2'b00;
      r_bid     <= '0;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bid     <= w_cur_awid;
      r_bresp   <= w_wr_ok ? 2'b00 : c_OOR_RESP;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= axi4_s.awaddr;
        r_awid    <= axi4_s.awid;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= axi4_s.wdata;
        r_wstrb  <= axi4_s.wstrb;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < R; k++) r_regs[k] <= '0;
      r_wr_pulse <= '0;
    end else begin
      for (int k = 0; k < R; k++) begin
        r_wr_pulse[k] <= w_commit & w_wr_ok & (w_widx == c_IDX_W'(k)) & (|w_cur_wstrb);
        for (int b = 0; b < N; b++) begin
          if (w_commit && w_wr_ok && (w_widx == c_IDX_W'(k)) && w_cur_wstrb[b])
            r_regs[k][b*8 +: 8] <= w_cur_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read data is sampled before any same-edge write commit lands.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rdata <= '0;
      r_rresp <= 2'b00;
      r_rid   <= '0;
    end else if (w_ar_hs) begin
      r_rdata <= addr_ok(axi4_s.araddr) ? r_regs[w_ridx] : '0;
      r_rresp <= addr_ok(axi4_s.araddr) ? 2'b00 : c_OOR_RESP;
      r_rid   <= axi4_s.arid;
    end
  end

  for (genvar k = 0; k < R; k++) begin : g_reg_q
    assign reg_q[k*c_DW +: c_DW] = r_regs[k];
  end

  assign wr_pulse     = r_wr_pulse;
  assign axi4_s.bresp = r_bresp;
  assign axi4_s.bid   = r_bid;
  assign axi4_s.rdata = r_rdata;
  assign axi4_s.rresp = r_rresp;
  assign axi4_s.rid   = r_rid;

endmodule
`default_nettype wire
